// File: rtl/seq_pkg.sv
// Shared types for the datapath sequencer: opcodes, ALU encodings, FSM states,
// the decoded control bundle and the field layout of a program word.
package seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LDI = 3'd1,
    OP_WR  = 3'd2,
    OP_RD  = 3'd3,
    OP_INC = 3'd4,
    OP_ADD = 3'd5,
    OP_END = 3'd6,
    OP_ILL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_INC  = 2'd1,
    ALU_ADD  = 2'd2
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic    mbr_load;
    logic    mbr_sel;
    logic    mem_wr;
    logic    mem_rd;
    logic    b_mdr;
    alu_op_e alu_op;
    logic    h_load;
  } ctrl_t;

  // Program word is {op, addr, imm} with imm in the least significant bits.
  localparam int IMM_LSB = 0;

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int op_lsb(input int data_w, input int addr_w);
    return data_w + addr_w;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: maps the latched opcode to its EXEC
// length and to the datapath strobes for the current EXEC cycle.
module seq_decode
  import seq_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int ALU_LAT  = 2,
  parameter int CNT_W    = 2
) (
  input  op_e              op,
  input  logic             last,
  output logic [CNT_W-1:0] len,
  output ctrl_t            ctrl
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    len  = CNT_W'(1);
    ctrl = '0;
    case (op)
      OP_LDI: ctrl.mbr_load = 1'b1;
      OP_WR:  ctrl.mem_wr   = 1'b1;
      OP_RD: begin
        len         = CNT_W'(READ_LAT);
        ctrl.mem_rd = 1'b1;
      end
      OP_INC: begin
        len           = CNT_W'(ALU_LAT);
        ctrl.b_mdr    = 1'b1;
        ctrl.alu_op   = ALU_INC;
        ctrl.h_load   = last;
        ctrl.mbr_load = last;
        ctrl.mbr_sel  = last;
      end
      OP_ADD: begin
        len           = CNT_W'(ALU_LAT);
        ctrl.b_mdr    = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        ctrl.mbr_load = last;
        ctrl.mbr_sel  = last;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Microprogrammed control FSM that fetches control words from a program ROM and
// drives datapath strobes for each op's fixed latency. Optional macro:
// SEQ_SINGLE_STEP_EN adds a step input and a HOLD state after every EXEC.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4,
  parameter int PC_W     = 4,
  parameter int READ_LAT = 2,
  parameter int ALU_LAT  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                          step,
`endif
  output logic [PC_W-1:0]               prog_addr,
  input  logic [OP_W+ADDR_W+DATA_W-1:0] prog_word,
  output logic                          mbr_load,
  output logic                          mbr_sel,
  output logic [DATA_W-1:0]             imm,
  output logic                          mem_wr,
  output logic                          mem_rd,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          b_mdr,
  output logic [1:0]                    alu_op,
  output logic                          h_load,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int MAX_LAT  = (READ_LAT > ALU_LAT) ? READ_LAT : ALU_LAT;
  localparam int CNT_W    = $clog2(MAX_LAT + 1);
  localparam int OPF_LSB  = op_lsb(DATA_W, ADDR_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);

  state_e            state, state_nxt;
  logic [PC_W-1:0]   pc;
  op_e               ir_op;
  logic [ADDR_W-1:0] ir_addr;
  logic [DATA_W-1:0] ir_imm;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len;
  logic              err_q;
  logic              last;
  logic              pc_max;
  op_e               fetch_op;
  ctrl_t             dec_ctrl;

  assign fetch_op = op_e'(prog_word[OPF_LSB +: OP_W]);
  assign last     = (cnt == len - CNT_W'(1));
  assign pc_max   = (pc == '1);

  seq_decode #(
    .READ_LAT (READ_LAT),
    .ALU_LAT  (ALU_LAT),
    .CNT_W    (CNT_W)
  ) u_decode (
    .op   (ir_op),
    .last (last),
    .len  (len),
    .ctrl (dec_ctrl)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (fetch_op == OP_END || fetch_op == OP_ILL) state_nxt = S_DONE;
        else                                          state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (last) begin
          // The last ROM address ends the run instead of wrapping to PC 0.
          if (pc_max) state_nxt = S_DONE;
`ifdef SEQ_SINGLE_STEP_EN
          else        state_nxt = S_HOLD;
`else
          else        state_nxt = S_FETCH;
`endif
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_HOLD: if (step) state_nxt = S_FETCH;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // IR is only replaced by executable ops, so mem_addr/imm keep the last
  // executed instruction's fields through DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      ir_op   <= OP_NOP;
      ir_addr <= '0;
      ir_imm  <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            err_q <= 1'b0;
          end
        end
        S_FETCH: begin
          cnt <= '0;
          if (fetch_op == OP_ILL) begin
            err_q <= 1'b1;
          end else if (fetch_op != OP_END) begin
            ir_op   <= fetch_op;
            ir_addr <= prog_word[ADDR_LSB +: ADDR_W];
            ir_imm  <= prog_word[IMM_LSB +: DATA_W];
          end
        end
        S_EXEC: begin
          if (last) begin
            if (!pc_max) pc <= pc + PC_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mbr_load = 1'b0;
    mbr_sel  = 1'b0;
    mem_wr   = 1'b0;
    mem_rd   = 1'b0;
    b_mdr    = 1'b0;
    alu_op   = ALU_PASS;
    h_load   = 1'b0;
    case (state)
      S_FETCH, S_HOLD: busy = 1'b1;
      S_EXEC: begin
        busy     = 1'b1;
        mbr_load = dec_ctrl.mbr_load;
        mbr_sel  = dec_ctrl.mbr_sel;
        mem_wr   = dec_ctrl.mem_wr;
        mem_rd   = dec_ctrl.mem_rd;
        b_mdr    = dec_ctrl.b_mdr;
        alu_op   = dec_ctrl.alu_op;
        h_load   = dec_ctrl.h_load;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign prog_addr = pc;
  assign mem_addr  = ir_addr;
  assign imm       = ir_imm;
  assign err       = err_q;

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Microprogrammed control FSM that drives the processor datapath's control strobes for MBR, memory, MDR, B bus, ALU and H. It replaces manual per-step switch sequencing: it fetches control words from an external program ROM and issues each operation for exactly its required latency. It sits between the program ROM and the datapath in `cpu_fpga`. It exposes a start/busy/done handshake.

## Interface
- `DATA_W`, 4: datapath word width (MBR/MDR/H/immediate)
- `ADDR_W`, 4: memory address width
- `PC_W`, 4: program counter width (ROM depth 2^PC_W)
- `READ_LAT`, 2: cycles from read issue to MDR valid (≥1)
- `ALU_LAT`, 2: cycles from MDR-to-B-bus enable to H/MBR capture (≥1)
- `clk` in 1: system clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: begin program at PC 0; sampled only in IDLE
- `step` in 1: advance from HOLD (exists only with `SEQ_SINGLE_STEP_EN`)
- `prog_addr` out PC_W: ROM address (= PC)
- `prog_word` in 3+ADDR_W+DATA_W: {op[2:0], addr, imm}; combinational ROM data
- `mbr_load` out 1: MBR capture strobe
- `mbr_sel` out 1: MBR source; 0 = `imm`, 1 = ALU
- `imm` out DATA_W: immediate to MBR
- `mem_wr` out 1: write MBR to `mem_addr`
- `mem_rd` out 1: read `mem_addr` into MDR
- `mem_addr` out ADDR_W: memory address
- `b_mdr` out 1: drive MDR onto the B bus
- `alu_op` out 2: 0 = pass, 1 = B+1, 2 = H+B
- `h_load` out 1: H capture strobe
- `busy` out 1: program running
- `done` out 1: one-cycle end pulse
- `err` out 1: illegal opcode seen; sticky

## Operation
- Opcodes:
  - 0 NOP
  - 1 LDI: MBR ← imm
  - 2 WR: mem[addr] ← MBR
  - 3 RD: MDR ← mem[addr]
  - 4 INC: H, MBR ← MDR+1
  - 5 ADD: MBR ← H+MDR
  - 6 END
  - 7 illegal
- States: IDLE, FETCH, EXEC, HOLD (macro only), DONE.
- IDLE → FETCH on `start`; PC ← 0; `err` cleared.
- FETCH: IR ← `prog_word`.
  - END → DONE.
  - Illegal → `err` ← 1, then DONE.
  - Otherwise → EXEC, with counter loaded.
- EXEC length:
  - NOP, LDI, WR: 1 cycle.
  - RD: READ_LAT cycles.
  - INC, ADD: ALU_LAT cycles.
  - On the last cycle, PC ← PC+1, then FETCH (or HOLD).
- Controls during EXEC (all other strobes 0):
  - LDI: `mbr_load`=1, `mbr_sel`=0.
  - WR: `mem_wr`=1.
  - RD: `mem_rd` held high for all READ_LAT cycles.
  - INC: `b_mdr`=1, `alu_op`=1 for all cycles; `h_load`, `mbr_load` (`mbr_sel`=1) only on the last cycle.
  - ADD: same as INC with `alu_op`=2 and no `h_load`.
- Outputs are Moore: decoded from state and IR only, never from `prog_word` directly.
- `mem_addr` and `imm` come from IR; they hold their last value outside EXEC.
- PC wrap: after executing address 2^PC_W−1 with no END, go to DONE. PC never wraps to 0 mid-run.
- `start` while busy is ignored. `start` high in DONE is ignored; it is sampled again in IDLE.
- Reset (any time, including mid-EXEC):
  - State IDLE; PC, IR and counter 0.
  - All strobes 0; `busy`, `done`, `err` 0; `prog_addr` 0; `mem_addr`, `imm` 0.

## Timing
- `start` sampled at edge 0 → FETCH in cycle 1 (`prog_addr`=0) → first EXEC cycle 2.
- Each instruction costs 1 FETCH cycle + its EXEC length.
- `busy` = 1 in FETCH, EXEC and HOLD; 0 in IDLE and DONE.
- `done` = 1 for exactly the single DONE cycle, followed by IDLE.
- No backpressure from the datapath; the latency parameters are the contract.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - After each EXEC completes, enter HOLD; `busy` stays 1 and all strobes are 0.
  - Leave HOLD to FETCH on the first cycle `step`=1.
  - `step` during FETCH/EXEC is ignored.
  - END and illegal opcodes do not pass through HOLD.
- Undefined: no `step` port, no HOLD state; EXEC goes directly to FETCH.

## Structure
- Package `seq_pkg`: opcode constants, `alu_op` encodings, state enum, and field-slice positions within `prog_word`.
- Optional sub-module `seq_decode`: purely combinational, IR op → EXEC length and control strobes. FSM, PC and counter stay in the top.

## Test plan
- Default program LDI 1; WR 1; RD 1; INC; WR 2; RD 2; ADD; WR 4; RD 4; END, with a datapath model:
  - Writes: mem[1]=1, mem[2]=2, mem[4]=4.
  - Final MDR=4.
  - `busy` high exactly 24 cycles, then `done` for 1 cycle.
- Program with op 7 at PC 3: `err`=1 after the FETCH of PC 3, then `done` pulse. Only PCs 0–2 execute. `err` clears on the next `start`.
- 16 NOPs, no END: `prog_addr` reaches 15, then DONE. Total busy cycles = 32. PC not re-fetched at 0.
- Assert `rst` during the second RD EXEC cycle: all strobes and `busy` drop immediately (asynchronous). Next `start` restarts at PC 0.
- `start` pulsed while busy and during DONE: no restart. Trace identical to the single-start run.
- With `SEQ_SINGLE_STEP_EN`, program LDI 3; END:
  - After the LDI EXEC, stays in HOLD with `busy`=1 for 10 cycles with no strobes.
  - `step` → FETCH of END → `done`.
